// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-port burst master.
package mem_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned CNT_W         = 5;
    localparam logic [31:0] START_ADDRESS = 32'h8002_0000;

    typedef enum logic [1:0] {
        ACC_1  = 2'b00,
        ACC_4  = 2'b01,
        ACC_8  = 2'b10,
        ACC_16 = 2'b11
    } acc_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_RD_WAIT,
        ST_READ
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        acc_size_e         size;
    } req_t;

    function automatic logic [CNT_W-1:0] burst_len(input acc_size_e size);
        case (size)
            ACC_1:  burst_len = CNT_W'(1);
            ACC_4:  burst_len = CNT_W'(4);
            ACC_8:  burst_len = CNT_W'(8);
            ACC_16: burst_len = CNT_W'(16);
        endcase
    endfunction

endpackage

// File: rtl/mem_burst_wbuf.sv
// Write-data staging buffer: synchronous write, combinational read so the
// selected word lines up with the write-enable cycle.
module mem_burst_wbuf
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the main memory port: buffers write bursts, then
// streams them out; issues read bursts and returns a registered stream.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_in_o,
    input  logic [31:0] mem_data_out_i,
    output logic [1:0]  mem_acc_size_o,
    output logic        mem_wren_o,
    input  logic        mem_busy_i,
    output logic        mem_enable_o
);

    localparam int unsigned IDX_W = $clog2(MAX_BURST);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;

    logic               arm_q, arm_d;
    logic               wr_ready_q, wr_ready_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_data_in_q, mem_data_in_d;
    acc_size_e          mem_acc_size_q, mem_acc_size_d;
    logic               mem_wren_q, mem_wren_d;
    logic               mem_enable_q;

    logic               accept;
    logic               misaligned;
    logic               wr_fire;
    logic [CNT_W-1:0]   len;
    logic [DATA_W-1:0]  buf_rdata;

    // Busy bypasses the ready register so a request lands on the first idle-and-free cycle.
    assign req_ready_o = arm_q && !mem_busy_i;
    assign accept      = req_valid_i && req_ready_o;
    assign misaligned  = |req_addr_i[1:0];
    assign wr_fire     = wr_valid_i && wr_ready_q;
    assign len         = burst_len(req_q.size);

    mem_burst_wbuf #(
        .DEPTH (MAX_BURST)
    ) u_wbuf (
        .clock_i (clock_i),
        .we_i    (wr_fire),
        .waddr_i (cnt_q[IDX_W-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (cnt_q[IDX_W-1:0]),
        .rdata_o (buf_rdata)
    );

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic; cnt_q indexes fill words, write beats and read latency/beats
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.addr = req_addr_i;
                    req_d.size = acc_size_e'(req_size_i);
                    cnt_d      = '0;
                    if (!misaligned) begin
                        state_d = req_write_i ? ST_FILL : ST_RD_WAIT;
                    end
                end
            end
            ST_FILL: begin
                if (wr_fire) begin
                    if (cnt_q == len - CNT_W'(1)) begin
                        state_d = ST_WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == len) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == CNT_W'(RD_LATENCY)) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (cnt_q == len - CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        arm_d          = (state_q == ST_IDLE) && (state_d == ST_IDLE) && !accept;
        wr_ready_d     = (state_d == ST_FILL);
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        done_d         = 1'b0;
        err_d          = (state_q == ST_IDLE) && accept && misaligned;
        mem_addr_d     = mem_addr_q;
        mem_data_in_d  = mem_data_in_q;
        mem_acc_size_d = mem_acc_size_q;
        mem_wren_d     = 1'b0;
        case (state_q)
            ST_WRITE: begin
                if (cnt_q < len) begin
                    mem_wren_d     = 1'b1;
                    mem_addr_d     = req_q.addr;
                    mem_acc_size_d = req_q.size;
                    mem_data_in_d  = buf_rdata;
                end else begin
                    done_d = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    mem_addr_d     = req_q.addr;
                    mem_acc_size_d = req_q.size;
                end
            end
            ST_READ: begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_data_out_i;
                done_d     = (cnt_q == len - CNT_W'(1));
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            arm_q          <= 1'b0;
            wr_ready_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_in_q  <= '0;
            mem_acc_size_q <= ACC_1;
            mem_wren_q     <= 1'b0;
            mem_enable_q   <= 1'b0;
        end else begin
            arm_q          <= arm_d;
            wr_ready_q     <= wr_ready_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            done_q         <= done_d;
            err_q          <= err_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_acc_size_q <= mem_acc_size_d;
            mem_wren_q     <= mem_wren_d;
            mem_enable_q   <= 1'b1;
        end
    end

    assign wr_ready_o     = wr_ready_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_in_o  = mem_data_in_q;
    assign mem_acc_size_o = mem_acc_size_q;
    assign mem_wren_o     = mem_wren_q;
    assign mem_enable_o   = mem_enable_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed + randomized bench for mem_burst_master with a word-array memory
// model and a reference memory image built from the requested writes.
module tb_mem_burst_master;
    import mem_pkg::*;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, done, err;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic [1:0]  mem_acc_size;
    logic        mem_wren, mem_busy, mem_enable;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic        mem_init;
    logic [31:0] mem_phys [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] wdat     [16];
    int          wcnt;

    always #5 clk = ~clk;

    mem_burst_master #(.RD_LATENCY(RDL), .MAX_BURST(16)) dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_write_i    (req_write),
        .req_size_i     (req_size),
        .wr_data_i      (wr_data),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .done_o         (done),
        .err_o          (err),
        .mem_addr_o     (mem_addr),
        .mem_data_in_o  (mem_data_in),
        .mem_data_out_i (mem_data_out),
        .mem_acc_size_o (mem_acc_size),
        .mem_wren_o     (mem_wren),
        .mem_busy_i     (mem_busy),
        .mem_enable_o   (mem_enable)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a - START_ADDRESS) >> 2) & 255;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic int blen(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Memory model: write bursts land at consecutive words from the held address
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_phys[i] <= init_word(i);
            wcnt <= 0;
        end else if (mem_wren && mem_enable) begin
            mem_phys[(widx(mem_addr) + wcnt) & 255] <= mem_data_in;
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_mem_wren"}, mem_wren, 0);
        check({tag, "_mem_enable"}, mem_enable, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data_in"}, mem_data_in, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_acc_size"}, 32'(mem_acc_size), 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] sz,
                            input bit gaps, input int abort_k);
        int n, base, g;
        bit aborted;
        n = blen(sz); base = widx(addr); aborted = 1'b0;
        req_valid = 1'b1; req_addr = addr; req_write = 1'b1; req_size = sz;
        #1; check("wr_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_write = 1'b0;
        check("wr_accept_ready", req_ready, 0);
        check("fill_wr_ready", wr_ready, 1);
        for (int i = 0; i < n; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int q = 0; q < g; q++) begin
                wr_valid = 1'b0; wr_data = $urandom;
                @(posedge clk); #1;
                check("gap_wr_ready", wr_ready, 1);
                check("gap_wren", mem_wren, 0);
            end
            wr_valid = 1'b1; wr_data = wdat[i];
            @(posedge clk); #1;
        end
        wr_data = $urandom;
        check("fill_end_wr_ready", wr_ready, 0);
        check("fill_end_wren", mem_wren, 0);
        for (int k = 0; k < n && !aborted; k++) begin
            if (k == abort_k) begin
                reset = 1'b1;
                @(posedge clk); #1;
                check_reset_vals("abort");
                reset = 1'b0; wr_valid = 1'b0;
                @(posedge clk); #1;
                check("abort_enable", mem_enable, 1);
                check("abort_ready", req_ready, 1);
                check("abort_no_done", done, 0);
                check("abort_wren", mem_wren, 0);
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
                check("wr_wren", mem_wren, 1);
                check("wr_addr", mem_addr, addr);
                check("wr_size", 32'(mem_acc_size), 32'(sz));
                check("wr_data", mem_data_in, wdat[k]);
                check("wr_done_early", done, 0);
                check("wr_wr_ready", wr_ready, 0);
                ref_mem[(base + k) & 255] = wdat[k];
            end
        end
        if (!aborted) begin
            wr_valid = 1'b0;
            @(posedge clk); #1;
            check("wr_end_wren", mem_wren, 0);
            check("wr_done", done, 1);
            check("wr_done_ready", req_ready, 0);
            @(posedge clk); #1;
            check("wr_done_clear", done, 0);
            check("wr_turnaround", req_ready, 1);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] sz, input int busy);
        int  n, base;
        bit  ev;
        n = blen(sz); base = widx(addr);
        req_valid = 1'b1; req_addr = addr; req_write = 1'b0; req_size = sz;
        mem_busy = (busy > 0);
        for (int b = 0; b < busy; b++) begin
            #1; check("busy_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        mem_busy = 1'b0;
        #1; check("rd_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; mem_data_out = $urandom;
        check("rd_accept_ready", req_ready, 0);
        for (int j = 1; j <= RDL + 2 + n; j++) begin
            @(posedge clk); #1;
            ev = (j >= RDL + 2) && (j <= RDL + 1 + n);
            check("rd_valid", rd_valid, 32'(ev));
            if (ev) check("rd_data", rd_data, ref_mem[(base + j - RDL - 2) & 255]);
            check("rd_done", done, 32'(j == RDL + 1 + n));
            check("rd_wren", mem_wren, 0);
            if (j <= RDL + 1 + n) begin
                check("rd_addr", mem_addr, addr);
                check("rd_size", 32'(mem_acc_size), 32'(sz));
                check("rd_busy_ready", req_ready, 0);
            end else begin
                check("rd_turnaround", req_ready, 1);
            end
            if (j >= RDL + 1 && j < RDL + 1 + n)
                mem_data_out = mem_phys[(base + j - RDL - 1) & 255];
            else
                mem_data_out = $urandom;
        end
    endtask

    task automatic do_misaligned(input logic [31:0] addr, input bit wr);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_size = 2'($urandom_range(0, 3));
        wr_valid = 1'b1; wr_data = $urandom;
        #1; check("mis_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mis_err", err, 1);
        check("mis_ready_low", req_ready, 0);
        check("mis_wr_ready", wr_ready, 0);
        for (int c = 0; c < RDL + 4; c++) begin
            @(posedge clk); #1;
            check("mis_err_clear", err, 0);
            check("mis_ready_back", req_ready, 1);
            check("mis_no_wren", mem_wren, 0);
            check("mis_no_rd_valid", rd_valid, 0);
            check("mis_no_done", done, 0);
            check("mis_no_fill", wr_ready, 0);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0;
        wr_data = '0; wr_valid = 1'b0; mem_data_out = '0; mem_busy = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;
        check("post_reset_enable", mem_enable, 1);
        check("post_reset_ready", req_ready, 1);

        // Single write then single read of the same word
        wdat[0] = 32'h8C22_0000;
        do_write(START_ADDRESS, 2'b00, 1'b0, -1);
        do_read(START_ADDRESS, 2'b00, 0);

        // 4-word burst with write-data gaps
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        do_write(START_ADDRESS + 32'h4, 2'b01, 1'b1, -1);
        do_read(START_ADDRESS + 32'h4, 2'b01, 0);

        // 8- and 16-word bursts
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        do_write(START_ADDRESS + 32'h40, 2'b10, 1'b0, -1);
        do_read(START_ADDRESS + 32'h40, 2'b10, 0);
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        do_write(START_ADDRESS + 32'h80, 2'b11, 1'b1, -1);
        do_read(START_ADDRESS + 32'h80, 2'b11, 0);

        // Misaligned requests
        do_misaligned(32'h8002_0002, 1'b1);
        do_misaligned(32'h8002_0002, 1'b0);

        // Memory busy for 5 cycles with a pending request
        do_read(START_ADDRESS, 2'b00, 5);

        // Reset during a 16-word write at beat 5, then read back
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        do_write(START_ADDRESS + 32'hC0, 2'b11, 1'b0, 5);
        do_read(START_ADDRESS + 32'hC8, 2'b00, 0);
        do_read(START_ADDRESS + 32'hC0, 2'b11, 0);

        // Randomized write/read-back pairs
        for (int t = 0; t < 4; t++) begin
            logic [1:0] sz;
            int off;
            sz  = 2'($urandom_range(0, 3));
            off = int'($urandom_range(0, 240));
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            do_write(START_ADDRESS + 32'(off * 4), sz, 1'($urandom_range(0, 1)), -1);
            do_read(START_ADDRESS + 32'(off * 4), sz, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator-side engine for the main memory port: accepts single-word or 4/8/16-word burst requests from the pipeline (fetch/load-store side), and drives the memory's address/data/size/write-enable interface with exact cycle timing. Write data is buffered before the burst starts. Read data is returned as a registered stream. It replaces hand-sequenced memory access and is the sole driver of the memory port.

## Interface
- RD_LATENCY, 2, cycles from read command edge to first word on mem_data_out
- MAX_BURST, 16, write buffer depth in words
- clock  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- req_addr  in  32  byte address, word aligned
- req_write  in  1  1 = write burst, 0 = read burst
- req_size  in  2  00 = 1 word, 01 = 4, 10 = 8, 11 = 16 (same encoding as mem_acc_size)
- wr_data  in  32  write word
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted on wr_valid && wr_ready
- rd_data  out  32  returned read word
- rd_valid  out  1  rd_data valid; no backpressure
- done  out  1  one-cycle pulse at request completion
- err  out  1  one-cycle pulse: request rejected (misaligned)
- mem_addr  out  32  memory address
- mem_data_in  out  32  data to memory
- mem_data_out  in  32  data from memory
- mem_acc_size  out  2  burst size to memory
- mem_wren  out  1  memory write enable
- mem_busy  in  1  memory busy
- mem_enable  out  1  memory enable

## Operation
- States: IDLE, FILL, WRITE, RD_WAIT, READ.
- Reset values: state IDLE; req_ready, wr_ready, rd_valid, done, err, mem_wren, mem_enable = 0; mem_addr, mem_data_in, rd_data, mem_acc_size = 0.
- mem_enable = 1 every cycle after reset deasserts.
- IDLE: req_ready = !mem_busy. On accept, latch addr/size/write, N = 1/4/8/16.
  - If addr[1:0] != 0: err pulse next cycle, no memory access, stay IDLE.
  - Write → FILL; read → issue read command, go to RD_WAIT.
- FILL: wr_ready = 1, words stored at buf[0..N-1] in order. wr_valid gaps are allowed. After word N-1 → WRITE.
- WRITE: N consecutive cycles, k = 0..N-1. Each cycle drives mem_wren = 1, mem_addr = latched addr, mem_acc_size = size, mem_data_in = buf[k]. mem_addr is held for all k, because memory increments internally. The cycle after the last word: mem_wren = 0, done pulse, → IDLE.
- Read command: mem_wren = 0, mem_addr = addr, mem_acc_size = size, held until the request completes.
- READ: capture N words on consecutive cycles. rd_data/rd_valid are registered copies.
- Ignored inputs: wr_valid outside FILL (wr_ready = 0); req_valid outside IDLE (req_ready = 0).
- Reset mid-request: at the reset edge, all outputs return to reset values, the buffer is invalidated, and no done is issued.
- mem_busy is sampled only in IDLE. Once started, a burst is never paused.

## Timing
- Write burst: first mem_wren edge is 1 cycle after the FILL→WRITE transition. There are exactly N consecutive mem_wren = 1 cycles. done is asserted in the cycle mem_wren returns to 0.
- Read: the command is visible from edge T (the accept edge + 1). Word k is present on mem_data_out during cycle T+RD_LATENCY+k. rd_valid is high in cycle T+RD_LATENCY+k+1, for N consecutive cycles. done coincides with the last rd_valid.
- Minimum turnaround: req_ready reasserts the cycle after done.
- Single-word read, end to end: accept → rd_valid in RD_LATENCY+2 cycles.

## Structure
- Package mem_pkg:
  - acc_size encodings
  - burst_len(size) function returning 1/4/8/16
  - state enum
  - START_ADDRESS = 0x80020000
- Sub-module mem_burst_wbuf: MAX_BURST×32 register file. One write port (FILL index) and one read port (WRITE index), with synchronous write. Its read must be combinational so buf[k] appears in the same cycle as mem_wren.

## Test plan
- Single write 0x8C220000 to 0x80020000, then single read of the same address:
  - mem_wren high exactly 1 cycle.
  - rd_valid exactly RD_LATENCY+2 cycles after read accept, with rd_data = 0x8C220000.
  - done pulses once per request.
- 4-word write at 0x80020004 with wr_valid gaps, then 4-word read:
  - 4 back-to-back mem_wren cycles, mem_addr constant 0x80020004.
  - 4 consecutive rd_valid in order.
- 8-word and 16-word bursts:
  - mem_acc_size = 10 / 11.
  - Read data matches written data word-for-word.
  - No gap in rd_valid.
- req_addr 0x80020002: err pulse, no mem_wren, no rd_valid, req_ready back next cycle.
- mem_busy held high 5 cycles while req_valid = 1: req_ready = 0 throughout. Accepted on the first cycle busy is low.
- Reset asserted in WRITE at k = 5 of 16:
  - mem_wren = 0 at the reset edge, no done.
  - A subsequent single-word read returns correct data.
